crc32_frame_tx: RTL and testbench

CRC32_FRAME_TX -- requirements
Module: crc32_frame_tx

---
 rtl/crc32_frame_tx.sv | 140 ++++++++++++++
 tb/tb_crc32_frame_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_tx.sv
// crc32_frame_tx: forwards 32-bit payload words and appends a CRC-32 FCS word to each frame.
// Define CRC32_FINAL_XOR_EN to invert the final CRC (Ethernet FCS); by default the raw register is emitted.
module crc32_frame_tx #(
  parameter logic [15:0] MAX_WORDS = 16'd375
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        len_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    DATA     = 2'd0,
    FCS_LOAD = 2'd1,
    FCS_WAIT = 2'd2
  } state_e;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  // Reflected CRC-32 over one word; bit i of the word is the i-th bit on the wire.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_last_q, m_last_d;
  logic        len_err_q, len_err_d;

  logic        out_free;
  logic        in_fire;
  logic        out_fire;
  logic        max_hit;
  logic [31:0] fcs;

  assign out_free = !m_valid_q || m_ready;
  assign s_ready  = (state_q == DATA) && out_free;
  assign in_fire  = s_valid && s_ready;
  assign out_fire = m_valid_q && m_ready;
  assign max_hit  = (wcnt_q + 16'd1) == MAX_WORDS;

`ifdef CRC32_FINAL_XOR_EN
  assign fcs = crc_q ^ CRC_INIT;
`else
  assign fcs = crc_q;
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    crc_d       = crc_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_ready;
    m_last_d    = m_last_q && !m_ready;
    len_err_d   = 1'b0;

    unique case (state_q)
      DATA: begin
        if (in_fire) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          crc_d     = crc32_word(crc_q, s_data);
          wcnt_d    = wcnt_q + 16'd1;
          if (s_last || max_hit) begin
            state_d   = FCS_LOAD;
            len_err_d = max_hit && !s_last;
          end
        end
      end
      FCS_LOAD: begin
        if (out_free) begin
          m_data_d  = fcs;
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          state_d   = FCS_WAIT;
        end
      end
      FCS_WAIT: begin
        if (out_fire) begin
          crc_d       = CRC_INIT;
          wcnt_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = DATA;
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      state_q     <= DATA;
      crc_q       <= CRC_INIT;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      wcnt_q      <= wcnt_d;
      frame_cnt_q <= frame_cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      len_err_q   <= len_err_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign len_err   = len_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc32_frame_tx.sv
// Directed testbench for crc32_frame_tx (MAX_WORDS=4); expected FCS values follow CRC32_FINAL_XOR_EN.
module tb_crc32_frame_tx;

  localparam logic [15:0] MAXW = 16'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        len_err;
  logic [15:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_q[$];
  logic        in_last_q[$];
  logic [31:0] out_d[$];
  logic        out_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  int          lenerr_cnt;
  int          stab_err;
  int          b2b_err;
  bit          timed_out;

  crc32_frame_tx #(.MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .len_err  (len_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Byte-at-a-time reference CRC: xor the byte into the low bits, then eight reflected shifts.
  function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [31:0] w);
    logic [31:0] c;
    logic [7:0]  b;
    c = crc;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      c = c ^ {24'd0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] fcs_of(input logic [31:0] raw);
`ifdef CRC32_FINAL_XOR_EN
    return ~raw;
`else
    return raw;
`endif
  endfunction

  // Drives in_q upstream and collects accepted output words until n_fcs FCS words are seen.
  task automatic run_stream(input int n_fcs, input bit toggle, input int max_cycles);
    int          idx;
    int          cyc;
    int          fcs_seen;
    logic        hold;
    logic [31:0] hd;
    logic        hl;
    logic        in_acc;
    logic        out_acc;
    idx = 0; cyc = 0; fcs_seen = 0;
    out_d.delete(); out_l.delete();
    lenerr_cnt = 0; stab_err = 0; b2b_err = 0; timed_out = 1'b1;
    while (cyc < max_cycles) begin
      s_valid = (idx < in_q.size());
      s_data  = s_valid ? in_q[idx] : 32'd0;
      s_last  = s_valid ? in_last_q[idx] : 1'b0;
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      in_acc  = s_valid && s_ready;
      out_acc = m_valid && m_ready;
      hold    = m_valid && !m_ready;
      hd      = m_data;
      hl      = m_last;
      if (out_acc) begin
        out_d.push_back(m_data);
        out_l.push_back(m_last);
        if (m_last) fcs_seen++;
      end
      if (in_acc && out_acc && m_last) b2b_err++;
      if (in_acc) idx++;
      @(posedge clk);
      #1;
      if (len_err) lenerr_cnt++;
      if (hold && (m_valid !== 1'b1 || m_data !== hd || m_last !== hl)) stab_err++;
      cyc++;
      if (fcs_seen == n_fcs && idx == in_q.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0; m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 32'd0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    checks++; if (m_data !== 32'd0) begin errors++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
    @(posedge clk); #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_single_word(input string name, input logic [31:0] w, input logic [31:0] fcs_exp,
                                  input bit toggle);
    logic [15:0] fc0;
    fc0 = frame_cnt;
    in_q = '{w}; in_last_q = '{1'b1};
    exp_d = '{w, fcs_exp}; exp_l = '{1'b0, 1'b1};
    run_stream(1, toggle, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL %s_timeout: got no FCS expected one within 40 cycles", name); end
    checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, out_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
      checks++;
      if ({out_l[i], out_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL %s_word%0d: got last=%b data=%h expected last=%b data=%h", name, i, out_l[i], out_d[i], exp_l[i], exp_d[i]);
      end
    end
    checks++; if (frame_cnt !== fc0 + 16'd1) begin errors++; $display("FAIL %s_frame_cnt: got %h expected %h", name, frame_cnt, fc0 + 16'd1); end
    checks++; if (lenerr_cnt != 0) begin errors++; $display("FAIL %s_len_err: got %0d pulses expected 0", name, lenerr_cnt); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL %s_stall_stable: got %0d changes expected 0", name, stab_err); end
  endtask

  task automatic test_max_words();
    logic [31:0] c;
    in_q.delete(); in_last_q.delete(); exp_d.delete(); exp_l.delete();
    for (int k = 0; k < 7; k++) begin
      in_q.push_back(32'hA5C3_0000 + 32'(k * 32'h0101_0101));
      in_last_q.push_back(k == 6);
    end
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin c = crc_ref(c, in_q[k]); exp_d.push_back(in_q[k]); exp_l.push_back(1'b0); end
    exp_d.push_back(fcs_of(c)); exp_l.push_back(1'b1);
    c = 32'hFFFF_FFFF;
    for (int k = 4; k < 7; k++) begin c = crc_ref(c, in_q[k]); exp_d.push_back(in_q[k]); exp_l.push_back(1'b0); end
    exp_d.push_back(fcs_of(c)); exp_l.push_back(1'b1);
    run_stream(2, 1'b0, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL max_timeout: got incomplete stream expected 2 FCS words"); end
    checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL max_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
      checks++;
      if ({out_l[i], out_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL max_word%0d: got last=%b data=%h expected last=%b data=%h", i, out_l[i], out_d[i], exp_l[i], exp_d[i]);
      end
    end
    checks++; if (lenerr_cnt != 1) begin errors++; $display("FAIL max_len_err: got %0d pulses expected 1", lenerr_cnt); end
  endtask

  task automatic test_last_at_max();
    logic [31:0] c;
    in_q.delete(); in_last_q.delete(); exp_d.delete(); exp_l.delete();
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      in_q.push_back(32'h1357_9BDF ^ 32'(k << 8));
      in_last_q.push_back(k == 3);
      c = crc_ref(c, in_q[k]);
      exp_d.push_back(in_q[k]); exp_l.push_back(1'b0);
    end
    exp_d.push_back(fcs_of(c)); exp_l.push_back(1'b1);
    run_stream(1, 1'b0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL lastmax_timeout: got no FCS expected one"); end
    checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL lastmax_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
      checks++;
      if ({out_l[i], out_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL lastmax_word%0d: got last=%b data=%h expected last=%b data=%h", i, out_l[i], out_d[i], exp_l[i], exp_d[i]);
      end
    end
    checks++; if (lenerr_cnt != 0) begin errors++; $display("FAIL lastmax_len_err: got %0d pulses expected 0", lenerr_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] c;
    logic [15:0] fc0;
    fc0 = frame_cnt;
    in_q = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0001};
    in_last_q = '{1'b0, 1'b1, 1'b1};
    c = crc_ref(crc_ref(32'hFFFF_FFFF, in_q[0]), in_q[1]);
    exp_d = '{in_q[0], in_q[1], fcs_of(c), in_q[2], fcs_of(crc_ref(32'hFFFF_FFFF, in_q[2]))};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_stream(2, 1'b1, 80);
    checks++; if (timed_out) begin errors++; $display("FAIL b2b_timeout: got incomplete stream expected 2 FCS words"); end
    checks++; if (out_d.size() != exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", out_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < out_d.size(); i++) begin
      checks++;
      if ({out_l[i], out_d[i]} !== {exp_l[i], exp_d[i]}) begin
        errors++; $display("FAIL b2b_word%0d: got last=%b data=%h expected last=%b data=%h", i, out_l[i], out_d[i], exp_l[i], exp_d[i]);
      end
    end
    checks++; if (b2b_err != 0) begin errors++; $display("FAIL b2b_early_accept: got %0d overlaps expected 0", b2b_err); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL b2b_stall_stable: got %0d changes expected 0", stab_err); end
    checks++; if (frame_cnt !== fc0 + 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %h expected %h", frame_cnt, fc0 + 16'd2); end
  endtask

  task automatic test_reset_in_fcs_wait();
    m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h1122_3344; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++; if ({m_valid, m_last} !== 2'b11) begin errors++; $display("FAIL rstfcs_pending: got valid/last=%b%b expected 11", m_valid, m_last); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstfcs_m_valid: got %b expected 0", m_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstfcs_frame_cnt: got %h expected 0", frame_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstfcs_s_ready: got %b expected 1", s_ready); end
  endtask

  task automatic test_frame_cnt_wrap();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset: got %h expected ffff", frame_cnt); end
    in_q = '{32'h0000_0000}; in_last_q = '{1'b1};
    run_stream(1, 1'b0, 40);
    checks++; if (timed_out) begin errors++; $display("FAIL wrap_timeout: got no FCS expected one"); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt: got %h expected 0000", frame_cnt); end
  endtask

  initial begin
    logic [31:0] fcs_zero;
    logic [31:0] fcs_1234;
`ifdef CRC32_FINAL_XOR_EN
    fcs_zero = 32'h2144_DF1C;
    fcs_1234 = 32'h9BE3_E0A3;
`else
    fcs_zero = 32'hDEBB_20E3;
    fcs_1234 = 32'h641C_1F5C;
`endif
    test_reset();
    test_single_word("zero", 32'h0000_0000, fcs_zero, 1'b0);
    test_single_word("str1234", 32'h3433_3231, fcs_1234, 1'b0);
    test_single_word("stall1234", 32'h3433_3231, fcs_1234, 1'b1);
    test_max_words();
    test_last_at_max();
    test_back_to_back();
    test_reset_in_fcs_wait();
    test_single_word("postrst1234", 32'h3433_3231, fcs_1234, 1'b0);
    test_frame_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
